sv_xor_share_arb: RTL

//   Shares one registered bitwise-XOR unit among NREQ requesters using round-robin arbitration.

---
 rtl/sv_xor_share_arb.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sv_xor_share_arb.sv
// ---------------------------------------------------------------------------
// sv_xor_share_arb
//
// One registered bitwise-XOR unit shared by NREQ requesters under round-robin
// arbitration. Every request carries its own operand widths, result width and
// operand signedness. The result follows SystemVerilog binary-operator sizing:
// the XOR is signed only when both operands are signed; each operand is
// extended (sign or zero) to the common width and the result is truncated to
// the requested output width.
//
// Ports
//   clk        in   1         clock, all state on the rising edge
//   rst        in   1         asynchronous active-high reset
//   req_valid  in   NREQ      request i valid
//   req_ready  out  NREQ      request i accepted this cycle (one-hot or zero)
//   req_a      in   NREQ*W    operand A of requester i at [i*W +: W]
//   req_b      in   NREQ*W    operand B of requester i at [i*W +: W]
//   req_aw     in   NREQ*WW   A width at [i*WW +: WW]; 0 or >W means W
//   req_bw     in   NREQ*WW   B width, same encoding
//   req_ow     in   NREQ*WW   result width, same encoding
//   req_as     in   NREQ      A is signed
//   req_bs     in   NREQ      B is signed
//   out_valid  out  1         result valid
//   out_ready  in   1         consumer accepts the result
//   out_data   out  W         result, bits at or above the result width are 0
//   out_tag    out  TW        index of the requester that produced out_data
// ---------------------------------------------------------------------------
module sv_xor_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int WW   = $clog2(W) + 1,
    parameter int TW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*WW-1:0]   req_aw,
    input  logic [NREQ*WW-1:0]   req_bw,
    input  logic [NREQ*WW-1:0]   req_ow,
    input  logic [NREQ-1:0]      req_as,
    input  logic [NREQ-1:0]      req_bs,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [TW-1:0]        out_tag
);

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------

    // Decode a width field: 1..W is taken literally, 0 or anything above W
    // selects the full width.
    function automatic int eff_width(input logic [WW-1:0] w);
        int wi;
        wi = int'(w);
        return ((wi == 0) || (wi > W)) ? W : wi;
    endfunction

    // Keep the low 'wid' bits of v and fill the bits above with either the
    // operand's own top bit (signed) or zero (unsigned). Masking and extension
    // happen in one pass, so bits of v above 'wid' never leak into the result.
    function automatic logic [W-1:0] extend_operand(input logic [W-1:0] v,
                                                    input int           wid,
                                                    input logic         sgn);
        logic [W-1:0] ext;
        logic         top;
        top = v[wid-1];
        for (int i = 0; i < W; i++) begin
            ext[i] = (i < wid) ? v[i] : (sgn & top);
        end
        return ext;
    endfunction

    // Full evaluation of one request: operand extension, XOR, result
    // truncation. Signedness only applies when both operands are signed.
    function automatic logic [W-1:0] xor_eval(input logic [W-1:0]  a,
                                              input logic [W-1:0]  b,
                                              input logic [WW-1:0] aw,
                                              input logic [WW-1:0] bw,
                                              input logic [WW-1:0] ow,
                                              input logic          as_bit,
                                              input logic          bs_bit);
        logic         sgn;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] r;
        int           owe;
        sgn = as_bit & bs_bit;
        ea  = extend_operand(a, eff_width(aw), sgn);
        eb  = extend_operand(b, eff_width(bw), sgn);
        owe = eff_width(ow);
        r   = ea ^ eb;
        for (int i = 0; i < W; i++) begin
            r[i] = (i < owe) ? r[i] : 1'b0;
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State and internal signals
    // -----------------------------------------------------------------------
    logic [TW-1:0]   rr_ptr_r;
    logic            out_valid_r;
    logic [W-1:0]    out_data_r;
    logic [TW-1:0]   out_tag_r;

    logic            free_s;
    logic            grant_valid_s;
    logic [TW-1:0]   grant_idx_s;
    logic            accept_s;
    logic [NREQ-1:0] req_ready_s;
    logic [TW-1:0]   rr_ptr_next_s;
    logic [W-1:0]    result_s;

    // Single output register without a skid buffer: a new result may only be
    // loaded when the register is empty or being drained this cycle.
    assign free_s = !out_valid_r || out_ready;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_valid_s && req_valid[(int'(rr_ptr_r) + k) % NREQ]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = TW'((int'(rr_ptr_r) + k) % NREQ);
            end else begin
                grant_valid_s = grant_valid_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // No acceptance is possible while reset is asserted.
    assign accept_s = !rst && free_s && grant_valid_s;

    // One-hot ready at the granted requester, otherwise all zero.
    always_comb begin
        req_ready_s = '0;
        if (accept_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign req_ready = req_ready_s;

    // Pointer moves to the requester just after the one granted.
    always_comb begin
        rr_ptr_next_s = rr_ptr_r;
        if (grant_idx_s == TW'(NREQ - 1)) begin
            rr_ptr_next_s = '0;
        end else begin
            rr_ptr_next_s = grant_idx_s + TW'(1);
        end
    end

    // Select the granted request's fields and evaluate the XOR.
    always_comb begin
        result_s = xor_eval(req_a [int'(grant_idx_s) * W  +: W],
                            req_b [int'(grant_idx_s) * W  +: W],
                            req_aw[int'(grant_idx_s) * WW +: WW],
                            req_bw[int'(grant_idx_s) * WW +: WW],
                            req_ow[int'(grant_idx_s) * WW +: WW],
                            req_as[grant_idx_s],
                            req_bs[grant_idx_s]);
    end

    // Output register and round-robin pointer. A drain without a new grant
    // clears valid but keeps data/tag so the bus does not toggle needlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_tag_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_tag_r   <= grant_idx_s;
            rr_ptr_r    <= rr_ptr_next_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;

endmodule
